// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU control codes and the decoded payload types.
package rv_pkg;

  localparam int unsigned ImmW = 64;

  localparam logic [6:0] OpcR     = 7'b0110011;
  localparam logic [6:0] OpcILoad = 7'b0000011;
  localparam logic [6:0] OpcIAlu  = 7'b0010011;
  localparam logic [6:0] OpcS     = 7'b0100011;
  localparam logic [6:0] OpcB     = 7'b1100011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;
  localparam logic [6:0] OpcJal   = 7'b1101111;
  localparam logic [6:0] OpcJalr  = 7'b1100111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSll  = 4'b0001;
  localparam logic [3:0] AluSlt  = 4'b0010;
  localparam logic [3:0] AluSltu = 4'b0011;
  localparam logic [3:0] AluXor  = 4'b0100;
  localparam logic [3:0] AluSrl  = 4'b0101;
  localparam logic [3:0] AluOr   = 4'b0110;
  localparam logic [3:0] AluAnd  = 4'b0111;
  localparam logic [3:0] AluSub  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1101;

  // imm is kept at the widest XLEN; the stage truncates to its own width.
  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      alu_ctrl;
    logic [ImmW-1:0] imm;
    logic            op1_sel;
    logic            pc_sel;
    logic            w_en;
    logic            mw_en;
    logic            maddr_sel;
    logic [2:0]      dmem_ctrl;
    logic [2:0]      branch_ctrl;
    logic            jump_en;
    logic            link;
    logic            illegal;
  } decode_t;

  typedef struct packed {
    decode_t         dec;
    logic [ImmW-1:0] pc;
  } beat_t;

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} buf_state_e;

  // Decode of addi x0,x0,0.
  localparam decode_t DecNop = '{op1_sel: 1'b1, w_en: 1'b1, alu_ctrl: AluAdd, default: '0};

endpackage

// File: rtl/decode_core.sv
// Purely combinational RV32I instruction decoder producing the registered payload fields.
module decode_core
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0] inst_i,
  output decode_t     dec_o
);

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic            legal;

  always_comb begin
    opcode = inst_i[6:0];
    f3     = inst_i[14:12];
    dec_o  = '0;
    imm32  = '0;
    legal  = 1'b1;

    case (opcode)
      OpcR: begin
        dec_o.rs1      = inst_i[19:15];
        dec_o.rs2      = inst_i[24:20];
        dec_o.rd       = inst_i[11:7];
        dec_o.alu_ctrl = {inst_i[30], f3};
        dec_o.w_en     = 1'b1;
      end
      OpcIAlu: begin
        dec_o.rs1      = inst_i[19:15];
        dec_o.rd       = inst_i[11:7];
        // inst[30] only selects SRAI vs SRLI; elsewhere it is immediate data.
        dec_o.alu_ctrl = {(f3 == 3'b101) & inst_i[30], f3};
        imm32          = {{20{inst_i[31]}}, inst_i[31:20]};
        dec_o.op1_sel  = 1'b1;
        dec_o.w_en     = 1'b1;
      end
      OpcILoad: begin
        dec_o.rs1       = inst_i[19:15];
        dec_o.rd        = inst_i[11:7];
        imm32           = {{20{inst_i[31]}}, inst_i[31:20]};
        dec_o.op1_sel   = 1'b1;
        dec_o.w_en      = 1'b1;
        dec_o.maddr_sel = 1'b1;
        dec_o.dmem_ctrl = f3;
      end
      OpcS: begin
        dec_o.rs1       = inst_i[19:15];
        dec_o.rs2       = inst_i[24:20];
        imm32           = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
        dec_o.op1_sel   = 1'b1;
        dec_o.mw_en     = 1'b1;
        dec_o.dmem_ctrl = f3;
      end
      OpcB: begin
        dec_o.rs1         = inst_i[19:15];
        dec_o.rs2         = inst_i[24:20];
        imm32             = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                             inst_i[11:8], 1'b0};
        dec_o.branch_ctrl = f3;
        dec_o.jump_en     = 1'b1;
      end
      OpcLui: begin
        dec_o.rd      = inst_i[11:7];
        imm32         = {inst_i[31:12], 12'b0};
        dec_o.op1_sel = 1'b1;
        dec_o.w_en    = 1'b1;
      end
      OpcAuipc: begin
        dec_o.rd      = inst_i[11:7];
        imm32         = {inst_i[31:12], 12'b0};
        dec_o.op1_sel = 1'b1;
        dec_o.pc_sel  = 1'b1;
        dec_o.w_en    = 1'b1;
      end
      OpcJal: begin
        dec_o.rd      = inst_i[11:7];
        imm32         = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                         inst_i[30:21], 1'b0};
        dec_o.op1_sel = 1'b1;
        dec_o.pc_sel  = 1'b1;
        dec_o.w_en    = 1'b1;
        dec_o.jump_en = 1'b1;
        dec_o.link    = 1'b1;
      end
      OpcJalr: begin
        dec_o.rs1     = inst_i[19:15];
        dec_o.rd      = inst_i[11:7];
        imm32         = {{20{inst_i[31]}}, inst_i[31:20]};
        dec_o.op1_sel = 1'b1;
        dec_o.w_en    = 1'b1;
        dec_o.jump_en = 1'b1;
        dec_o.link    = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (inst_i[1:0] != 2'b11) legal = 1'b0;

    imm_x     = XLEN'($signed(imm32));
    dec_o.imm = ImmW'($signed(imm_x));

    if (!legal) begin
      dec_o.illegal = 1'b1;
      dec_o.w_en    = 1'b0;
      dec_o.mw_en   = 1'b0;
      dec_o.jump_en = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_core feeding a valid/ready elastic buffer with flush.
module decode_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned SKID      = 1,
  parameter int unsigned RESET_NOP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_alu_ctrl,
  output logic [XLEN-1:0] out_imm,
  output logic            out_op1_sel,
  output logic            out_pc_sel,
  output logic            out_w_en,
  output logic            out_mw_en,
  output logic            out_maddr_sel,
  output logic [2:0]      out_dmem_ctrl,
  output logic [2:0]      out_branch_ctrl,
  output logic            out_jump_en,
  output logic            out_link,
  output logic            out_illegal
);

  localparam beat_t ResetBeat = '{dec: (RESET_NOP != 0) ? DecNop : '0, pc: '0};

  decode_t    in_dec;
  beat_t      in_beat;
  beat_t      main_d, main_q, skid_d, skid_q;
  buf_state_e state_d, state_q;
  logic       accept, consume;

  decode_core #(
    .XLEN (XLEN)
  ) u_core (
    .inst_i (in_inst),
    .dec_o  (in_dec)
  );

  always_comb begin
    in_beat = '{dec: in_dec, pc: ImmW'(in_pc)};

    out_valid = (state_q != StEmpty);
    // A flushed beat is dropped, so the port can always report ready during flush.
    if (SKID != 0) begin
      in_ready = flush | (state_q != StTwo);
    end else begin
      in_ready = flush | (state_q == StEmpty) | out_ready;
    end
    accept  = in_valid & in_ready & ~flush;
    consume = out_valid & out_ready;

    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            main_d  = in_beat;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && consume) begin
            main_d = in_beat;
          end else if (accept) begin
            skid_d  = in_beat;
            state_d = StTwo;
          end else if (consume) begin
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (consume) begin
            main_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= ResetBeat;
      skid_q  <= ResetBeat;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    out_pc          = main_q.pc[XLEN-1:0];
    out_rs1         = main_q.dec.rs1;
    out_rs2         = main_q.dec.rs2;
    out_rd          = main_q.dec.rd;
    out_alu_ctrl    = main_q.dec.alu_ctrl;
    out_imm         = main_q.dec.imm[XLEN-1:0];
    out_op1_sel     = main_q.dec.op1_sel;
    out_pc_sel      = main_q.dec.pc_sel;
    out_w_en        = main_q.dec.w_en;
    out_mw_en       = main_q.dec.mw_en;
    out_maddr_sel   = main_q.dec.maddr_sel;
    out_dmem_ctrl   = main_q.dec.dmem_ctrl;
    out_branch_ctrl = main_q.dec.branch_ctrl;
    out_jump_en     = main_q.dec.jump_en;
    out_link        = main_q.dec.link;
    out_illegal     = main_q.dec.illegal;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, streaming, backpressure, flush, new ops, illegal, XLEN=64.
module tb_decode_stage;

  localparam int NB = 12;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_ctrl;
  logic        out_op1_sel, out_pc_sel, out_w_en, out_mw_en, out_maddr_sel;
  logic [2:0]  out_dmem_ctrl, out_branch_ctrl;
  logic        out_jump_en, out_link, out_illegal;

  logic        in_ready64, out_valid64;
  logic [63:0] out_pc64, out_imm64;
  logic [4:0]  out_rs1_64, out_rs2_64, out_rd_64;
  logic [3:0]  out_alu_ctrl64;
  logic        op1_64, pcs_64, wen_64, mwen_64, masel_64;
  logic [2:0]  dmem_64, br_64;
  logic        jmp_64, link_64, ill_64;

  int n_checks = 0;
  int n_fail   = 0;

  // Hand-encoded instructions and their hand-decoded fields.
  logic [31:0] t_inst [NB] = '{32'hFFD08293, 32'h002081B3, 32'h0020A423, 32'hFE208EE3,
                               32'h402081B3, 32'h00412303, 32'h4030D393, 32'h001000EF,
                               32'h123451B7, 32'h800001B7, 32'h00000000, 32'hFFFFFFFF};
  logic [4:0]  e_rd   [NB] = '{5, 3, 0, 0, 3, 6, 7, 1, 3, 3, 0, 0};
  logic [4:0]  e_rs1  [NB] = '{1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0, 0};
  logic [4:0]  e_rs2  [NB] = '{0, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0, 0};
  logic [3:0]  e_alu  [NB] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0, 4'hD, 4'h0, 4'h0, 4'h0,
                               4'h0, 4'h0};
  logic [31:0] e_imm  [NB] = '{32'hFFFFFFFD, 32'h0, 32'h8, 32'hFFFFFFFC, 32'h0, 32'h4,
                               32'h403, 32'h800, 32'h12345000, 32'h80000000, 32'h0, 32'h0};
  logic [63:0] e_imm64 [NB] = '{64'hFFFFFFFFFFFFFFFD, 64'h0, 64'h8, 64'hFFFFFFFFFFFFFFFC,
                                64'h0, 64'h4, 64'h403, 64'h800, 64'h12345000,
                                64'hFFFFFFFF80000000, 64'h0, 64'h0};
  // {op1_sel, pc_sel, w_en, mw_en, maddr_sel, jump_en, link, illegal}
  logic [7:0]  e_flg  [NB] = '{8'hA0, 8'h20, 8'h90, 8'h04, 8'h20, 8'hA8, 8'hA0, 8'hE6,
                               8'hA0, 8'hA0, 8'h01, 8'h01};
  logic [2:0]  e_dmem [NB] = '{0, 0, 2, 0, 0, 2, 0, 0, 0, 0, 0, 0};

  decode_stage #(.XLEN(32), .SKID(1), .RESET_NOP(1)) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready),
    .in_inst (in_inst), .in_pc (in_pc), .flush (flush), .out_valid (out_valid),
    .out_ready (out_ready), .out_pc (out_pc), .out_rs1 (out_rs1), .out_rs2 (out_rs2),
    .out_rd (out_rd), .out_alu_ctrl (out_alu_ctrl), .out_imm (out_imm),
    .out_op1_sel (out_op1_sel), .out_pc_sel (out_pc_sel), .out_w_en (out_w_en),
    .out_mw_en (out_mw_en), .out_maddr_sel (out_maddr_sel), .out_dmem_ctrl (out_dmem_ctrl),
    .out_branch_ctrl (out_branch_ctrl), .out_jump_en (out_jump_en), .out_link (out_link),
    .out_illegal (out_illegal)
  );

  decode_stage #(.XLEN(64), .SKID(1), .RESET_NOP(1)) dut64 (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid), .in_ready (in_ready64),
    .in_inst (in_inst), .in_pc ({32'h0, in_pc}), .flush (flush), .out_valid (out_valid64),
    .out_ready (out_ready), .out_pc (out_pc64), .out_rs1 (out_rs1_64), .out_rs2 (out_rs2_64),
    .out_rd (out_rd_64), .out_alu_ctrl (out_alu_ctrl64), .out_imm (out_imm64),
    .out_op1_sel (op1_64), .out_pc_sel (pcs_64), .out_w_en (wen_64), .out_mw_en (mwen_64),
    .out_maddr_sel (masel_64), .out_dmem_ctrl (dmem_64), .out_branch_ctrl (br_64),
    .out_jump_en (jmp_64), .out_link (link_64), .out_illegal (ill_64)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_beat(input int i);
    check_eq($sformatf("b%0d_valid", i), out_valid, 1);
    check_eq($sformatf("b%0d_pc", i), out_pc, 32'h1000 + 4 * i);
    check_eq($sformatf("b%0d_rd", i), out_rd, e_rd[i]);
    check_eq($sformatf("b%0d_rs1", i), out_rs1, e_rs1[i]);
    check_eq($sformatf("b%0d_rs2", i), out_rs2, e_rs2[i]);
    check_eq($sformatf("b%0d_alu", i), out_alu_ctrl, e_alu[i]);
    check_eq($sformatf("b%0d_imm", i), out_imm, e_imm[i]);
    check_eq($sformatf("b%0d_flags", i), {out_op1_sel, out_pc_sel, out_w_en, out_mw_en,
             out_maddr_sel, out_jump_en, out_link, out_illegal}, e_flg[i]);
    check_eq($sformatf("b%0d_dmem", i), out_dmem_ctrl, e_dmem[i]);
    check_eq($sformatf("b%0d_branch", i), out_branch_ctrl, 3'b000);
    check_eq($sformatf("b%0d_imm64", i), out_imm64, e_imm64[i]);
    check_eq($sformatf("b%0d_pc64", i), out_pc64, 64'h1000 + 64'(4 * i));
  endtask

  // Drives beats first..first+n-1 under an out_ready pattern, scoreboarding order and stability.
  task automatic run_stream(input int first, input int n, input logic [31:0] rdy_mask,
                            input int stall_cyc, input int exp_cycles);
    int          sent = 0;
    int          rcvd = 0;
    int          cyc  = 0;
    logic        held = 1'b0;
    logic [31:0] held_pc = '0;
    logic [31:0] held_imm = '0;
    while (rcvd < n && cyc < 40) begin
      in_valid  = (sent < n);
      in_inst   = t_inst[first + ((sent < n) ? sent : 0)];
      in_pc     = 32'h1000 + 32'(4 * (first + sent));
      out_ready = rdy_mask[cyc % 32];
      @(negedge clk);
      if (held) begin
        check_eq("stall_stable_pc", out_pc, held_pc);
        check_eq("stall_stable_imm", out_imm, held_imm);
        check_eq("stall_valid", out_valid, 1);
      end
      if (cyc == stall_cyc) begin
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_accepted", sent, 2);
      end
      if (out_valid && out_ready) begin
        check_beat(first + rcvd);
        rcvd++;
      end
      held     = out_valid && !out_ready;
      held_pc  = out_pc;
      held_imm = out_imm;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_eq("stream_received", rcvd, n);
    check_eq("stream_cycles", cyc, exp_cycles);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_imm", out_imm, 0);
    check_eq("rst_alu", out_alu_ctrl, 0);
    check_eq("rst_nop_flags", {out_op1_sel, out_w_en, out_mw_en, out_jump_en}, 4'b1100);
    check_eq("rst_out_valid64", out_valid64, 0);
    @(posedge clk);
    #1;

    // Full-throughput stream covering every format plus illegal words.
    run_stream(0, NB, 32'hFFFF_FFFF, -1, NB + 1);

    // Backpressure: out_ready low for four cycles while three beats are offered.
    run_stream(4, 3, 32'hFFFF_FFF0, 2, 7);

    // Flush with both entries full and a beat presented in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_inst = t_inst[1 + i];
      in_pc   = 32'h2000 + 32'(4 * i);
      @(posedge clk);
      #1;
    end
    in_inst = t_inst[3];
    in_pc   = 32'h2008;
    flush   = 1'b1;
    @(negedge clk);
    check_eq("flush_in_ready", in_ready, 1);
    check_eq("flush_prev_valid", out_valid, 1);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("post_flush_valid%0d", i), out_valid, 0);
      check_eq($sformatf("post_flush_ready%0d", i), in_ready, 1);
      @(posedge clk);
      #1;
    end

    // Stage must still work after a flush.
    run_stream(7, 2, 32'hFFFF_FFFF, -1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
